// File: rtl/portal_pkg.sv
// Shared types and constants for the portal teleport controller.
// Holds the FSM state enum, the coordinate type and both portal position sets.
package portal_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StWaitAck,
    StCooldown
  } state_e;

  typedef logic signed [10:0] coord_t;

  localparam int DefaultExitOffset = 16;

  // Position set A (loaded at reset)
  localparam coord_t SetABlueX   = 11'sd220;
  localparam coord_t SetABlueY   = 11'sd110;
  localparam coord_t SetAOrangeX = 11'sd440;
  localparam coord_t SetAOrangeY = 11'sd338;

  // Position set B
  localparam coord_t SetBBlueX   = 11'sd320;
  localparam coord_t SetBBlueY   = 11'sd171;
  localparam coord_t SetBOrangeX = 11'sd320;
  localparam coord_t SetBOrangeY = 11'sd310;

  // Wrapping 11-bit signed add of a portal corner and the landing offset.
  function automatic coord_t add_offset(coord_t pos, int offset);
    coord_t off;
    off = coord_t'(offset);
    return coord_t'(pos + off);
  endfunction

endpackage

// File: rtl/portal_rr_arb.sv
// Two-requester round-robin arbiter; the pointer moves past the winner on each taken grant.
// After reset requester 0 has priority.
module portal_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic prio1_q;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio1_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio1_q <= 1'b0;
    end else if (take && (req != 2'b00)) begin
      prio1_q <= gnt[0];
    end
  end

endmodule

// File: rtl/portal_teleport_ctrl.sv
// Portal teleport controller: grants one ball at a time, waits for ack or timeout, then cools down.
// Optional macro PORTAL_SHUFFLE_EN toggles portal position sets every SHUFFLE_PERIOD acked teleports.
module portal_teleport_ctrl
  import portal_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES    = 30,
  parameter int unsigned ACK_TIMEOUT_FRAMES = 4,
  parameter int          EXIT_OFFSET        = DefaultExitOffset,
  parameter int unsigned SHUFFLE_PERIOD     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic [1:0]         reqBlue,
  input  logic [1:0]         reqOrange,
  input  logic [1:0]         teleportAck,
  output logic [1:0]         teleportValid,
  output logic signed [10:0] teleportX,
  output logic signed [10:0] teleportY,
  output logic signed [10:0] topLeftXBlue,
  output logic signed [10:0] topLeftYBlue,
  output logic signed [10:0] topLeftXOrange,
  output logic signed [10:0] topLeftYOrange,
  output logic               busy
);

  localparam int unsigned FrameMax =
      (COOLDOWN_FRAMES > ACK_TIMEOUT_FRAMES) ? COOLDOWN_FRAMES : ACK_TIMEOUT_FRAMES;
  localparam int unsigned CntW = (FrameMax < 2) ? 1 : $clog2(FrameMax + 1);

  state_e          state_q;
  logic [CntW-1:0] frame_cnt_q;

  logic [1:0] req_any;
  logic [1:0] gnt;
  logic       grant_take;
  logic       entry_blue;
  coord_t     land_x;
  coord_t     land_y;
  logic       ack_ok;
  logic       ack_timeout;
  logic       cool_done;

  assign req_any    = reqBlue | reqOrange;
  assign grant_take = (state_q == StIdle) && (req_any != 2'b00);

  portal_rr_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_any),
    .take  (grant_take),
    .gnt   (gnt)
  );

`ifdef PORTAL_SHUFFLE_EN
  localparam int unsigned ShW = (SHUFFLE_PERIOD < 2) ? 1 : $clog2(SHUFFLE_PERIOD + 1);

  logic           set_b_q;
  logic [ShW-1:0] teleport_cnt_q;

  assign topLeftXBlue   = set_b_q ? SetBBlueX   : SetABlueX;
  assign topLeftYBlue   = set_b_q ? SetBBlueY   : SetABlueY;
  assign topLeftXOrange = set_b_q ? SetBOrangeX : SetAOrangeX;
  assign topLeftYOrange = set_b_q ? SetBOrangeY : SetAOrangeY;
`else
  assign topLeftXBlue   = SetABlueX;
  assign topLeftYBlue   = SetABlueY;
  assign topLeftXOrange = SetAOrangeX;
  assign topLeftYOrange = SetAOrangeY;
`endif

  // A ball touching both portals enters blue and so exits orange.
  assign entry_blue = reqBlue[gnt[1]];

  always_comb begin
    if (entry_blue) begin
      land_x = add_offset(topLeftXOrange, EXIT_OFFSET);
      land_y = add_offset(topLeftYOrange, EXIT_OFFSET);
    end else begin
      land_x = add_offset(topLeftXBlue, EXIT_OFFSET);
      land_y = add_offset(topLeftYBlue, EXIT_OFFSET);
    end
  end

  // Acks from the ball that does not hold the grant are masked out here.
  assign ack_ok      = (teleportAck & teleportValid) != 2'b00;
  assign ack_timeout = startOfFrame && (frame_cnt_q == CntW'(ACK_TIMEOUT_FRAMES - 1));
  assign cool_done   = startOfFrame && (frame_cnt_q == CntW'(COOLDOWN_FRAMES - 1));

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      frame_cnt_q   <= '0;
      teleportValid <= 2'b00;
      teleportX     <= '0;
      teleportY     <= '0;
`ifdef PORTAL_SHUFFLE_EN
      set_b_q        <= 1'b0;
      teleport_cnt_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_take) begin
            state_q       <= StGrant;
            frame_cnt_q   <= '0;
            teleportValid <= gnt;
            teleportX     <= land_x;
            teleportY     <= land_y;
          end
        end

        // Valid is already up in StGrant, so ack and timeout are honoured there too.
        StGrant, StWaitAck: begin
          if (ack_ok) begin
            state_q       <= StCooldown;
            frame_cnt_q   <= '0;
            teleportValid <= 2'b00;
`ifdef PORTAL_SHUFFLE_EN
            if (teleport_cnt_q == ShW'(SHUFFLE_PERIOD - 1)) begin
              teleport_cnt_q <= '0;
              set_b_q        <= ~set_b_q;
            end else begin
              teleport_cnt_q <= teleport_cnt_q + 1'b1;
            end
`endif
          end else if (ack_timeout) begin
            state_q       <= StCooldown;
            frame_cnt_q   <= '0;
            teleportValid <= 2'b00;
          end else begin
            state_q <= StWaitAck;
            if (startOfFrame) begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end

        StCooldown: begin
          if (cool_done) begin
            state_q     <= StIdle;
            frame_cnt_q <= '0;
          end else if (startOfFrame) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q       <= StIdle;
          teleportValid <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: doc/portal_teleport_ctrl.md
PORTAL_TELEPORT_CTRL -- requirements
Module: portal_teleport_ctrl

Interface
REQ-001 Parameter COOLDOWN_FRAMES, default 30: frames the portals stay inactive after a teleport completes.
REQ-002 Parameter ACK_TIMEOUT_FRAMES, default 4: frames to wait for a ball's acknowledge before the grant is dropped.
REQ-003 Parameter EXIT_OFFSET, default 16: signed offset added to exit-portal X and Y to form the landing point.
REQ-004 Parameter SHUFFLE_PERIOD, default 4: completed teleports between position-set swaps (used only under PORTAL_SHUFFLE_EN).
REQ-005 Ports: clk in 1, system clock. Single clock domain.
REQ-006 Ports: reset in 1, synchronous, active-high.
REQ-007 Ports: startOfFrame in 1, one-cycle pulse per VGA frame.
REQ-008 Ports: reqBlue in 2, bit i high means ball i overlaps the blue portal.
REQ-009 Ports: reqOrange in 2, bit i high means ball i overlaps the orange portal.
REQ-010 Ports: teleportAck in 2, bit i high means ball i move logic loaded the landing point.
REQ-011 Ports: teleportValid out 2, one-hot or zero, granted ball.
REQ-012 Ports: teleportX and teleportY out signed 11, landing point.
REQ-013 Ports: topLeftXBlue, topLeftYBlue, topLeftXOrange and topLeftYOrange out signed 11, portal positions driven to the portal drawers.
REQ-014 Ports: busy out 1, high in any state other than IDLE.

Function
REQ-015 The block SHALL implement the states IDLE, GRANT, WAIT_ACK and COOLDOWN.
REQ-016 IDLE transitions: any reqBlue or reqOrange bit set in cycle t SHALL cause GRANT at t+1; otherwise the block stays in IDLE.
REQ-017 Arbitration: if both balls request in the same cycle, the ball not granted last SHALL win (round-robin); after reset ball 0 has priority.
REQ-018 Portal priority: a ball with both reqBlue and reqOrange set SHALL be treated as blue-entry and exit orange.
REQ-019 GRANT: the block SHALL drive teleportValid[i] and teleportX/Y = exit portal top-left + EXIT_OFFSET, registered, and enter WAIT_ACK in the same cycle as valid.
REQ-020 Landing-point arithmetic: 11-bit signed, wrapping; the position tables SHALL keep results in 0..639 / 0..479.
REQ-021 WAIT_ACK: teleportValid and teleportX/Y SHALL remain stable until teleportAck[i] is high.
REQ-022 Acknowledge: valid SHALL deassert the cycle after teleportAck[i], and the state SHALL become COOLDOWN.
REQ-023 Non-granted ack: teleportAck for the non-granted ball SHALL be ignored.
REQ-024 Timeout: if ACK_TIMEOUT_FRAMES startOfFrame pulses pass in WAIT_ACK without ack, valid SHALL drop and the state SHALL become COOLDOWN; this does not count as a completed teleport.
REQ-025 COOLDOWN: the block SHALL count COOLDOWN_FRAMES startOfFrame pulses, ignore all requests, then return to IDLE.
REQ-026 Level-held requests: a request still asserted on return to IDLE SHALL be granted again, so the frame counter reaching zero does not re-trigger by itself.
REQ-027 Idle outputs: teleportX/Y SHALL hold their last value while teleportValid is low.

Reset
REQ-028 With reset high at a clk edge, the block SHALL enter IDLE, clear valid and busy, and set teleportX/Y to 0.
REQ-029 Reset SHALL also clear the frame counters and teleport counter, set the round-robin pointer to favour ball 0, and load position set A: blue (220,110), orange (440,338).
REQ-030 Reset mid-WAIT_ACK or mid-COOLDOWN SHALL abort immediately with no ack required.

Configuration
REQ-031 Macro PORTAL_SHUFFLE_EN defined: every SHUFFLE_PERIOD acknowledged teleports, on entry to COOLDOWN, the portal positions SHALL toggle between set A and set B: blue (320,171), orange (320,310).
REQ-032 Shuffle timing: positions SHALL never change outside COOLDOWN.
REQ-033 Macro PORTAL_SHUFFLE_EN undefined: positions SHALL be fixed at set A, and the teleport counter SHALL be absent.

Structure
REQ-034 Package portal_pkg SHALL hold the state enum, the coord_t typedef (signed 11-bit), the set A/B position constants and the default EXIT_OFFSET.
REQ-035 Sub-module portal_rr_arb SHALL provide two-requester round-robin arbitration, with a pointer update on grant.

Verification
REQ-036 Scenario: reqBlue=01 at cycle t -> teleportValid=01 at t+1 with teleportX=456, teleportY=354 (set A), busy=1.
REQ-037 Scenario: reqBlue=01 and reqOrange=10 simultaneously after reset -> ball 0 granted; the next request pair after cooldown -> ball 1 granted, landing (236,126).
REQ-038 Scenario: grant with no ack for 4 frames -> valid drops, COOLDOWN lasts 30 frames, then IDLE; requests during cooldown produce no grant.
REQ-039 Scenario: ack for the wrong ball -> valid held; correct ack -> valid low next cycle.
REQ-040 Scenario: PORTAL_SHUFFLE_EN with 4 acked teleports -> topLeftXBlue=320, topLeftYBlue=171 during the 4th cooldown; without the macro the positions stay 220/110.
REQ-041 Scenario: reset asserted in WAIT_ACK -> next cycle IDLE, valid=0, teleportX/Y=0.
